// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared types and helpers for the sequential ALU.
//   op_e    : operation encoding carried on the 3-bit op port
//   state_e : controller states (IDLE, SHIFT, DONE)
//   cc_t    : condition-code triple {negative, zero, positive}
//   cc_of() : derives the condition codes from a result's MSB and zero test
//   is_shift_op() : true for the three iterative shift operations
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_AND   = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOT   = 3'b011,
    OP_LSHF  = 3'b100,
    OP_RSHFL = 3'b101,
    OP_RSHFA = 3'b110,
    OP_PASS  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic positive;
  } cc_t;

  // Exactly one code is set: a zero result has a clear MSB, so negative and
  // zero can never both be true.
  function automatic cc_t cc_of(input logic msb, input logic is_zero);
    cc_t cc;
    cc.negative = msb;
    cc.zero     = is_zero;
    cc.positive = !msb && !is_zero;
    return cc;
  endfunction

  function automatic logic is_shift_op(input op_e op);
    return op inside {OP_LSHF, OP_RSHFL, OP_RSHFA};
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- purely combinational datapath of the sequential ALU.
//   op       : operation select
//   a, b     : operands (a is also the value being shifted)
//   result   : single-cycle result; shift ops return a unchanged, which is
//              the correct answer for a zero shift amount
//   overflow : signed overflow of ADD, 0 for every other op
//   step     : a shifted by exactly one bit in the direction chosen by op
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic [WIDTH-1:0] step
);

  logic [WIDTH-1:0] sum;

  // Carry out is discarded: ADD wraps modulo 2^WIDTH.
  assign sum = a + b;

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case statement can leave it unassigned (latch).
  always_comb begin
    result   = a;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_PASS: result = b;
      default: result = a;
    endcase
  end

  always_comb begin
    step = a;
    case (op)
      OP_LSHF:  step = {a[WIDTH-2:0], 1'b0};
      OP_RSHFL: step = {1'b0, a[WIDTH-1:1]};
      OP_RSHFA: step = {a[WIDTH-1], a[WIDTH-1:1]};
      default:  step = a;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish at the accept edge; shifts by k > 0 spend k cycles
// in SHIFT, one bit per cycle, before presenting the result in DONE.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready == state is IDLE)
//   in1, in2, op, shift : operand bundle captured on accept
//   out_valid, out_ready: output handshake (out_valid == state is DONE)
//   out                 : registered result
//   negative, zero, positive, overflow : registered condition codes
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             negative,
  output logic             zero,
  output logic             positive,
  output logic             overflow
);

  state_e           state;
  op_e              held_op;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;

  op_e              core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_result;
  logic             core_overflow;
  logic [WIDTH-1:0] core_step;
  cc_t              cc_result;
  cc_t              cc_step;
  logic             accept;

  // In IDLE the core sees the live inputs (single-cycle path); in SHIFT it
  // sees the captured op and the partially shifted working value.
  assign core_op = (state == IDLE) ? op_e'(op) : held_op;
  assign core_a  = (state == IDLE) ? in1 : work;
  assign accept  = (state == IDLE) && in_valid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (core_op),
    .a        (core_a),
    .b        (in2),
    .result   (core_result),
    .overflow (core_overflow),
    .step     (core_step)
  );

  assign cc_result = cc_of(core_result[WIDTH-1], core_result == '0);
  assign cc_step   = cc_of(core_step[WIDTH-1], core_step == '0);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      negative  <= 1'b0;
      zero      <= 1'b1;
      positive  <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      // NOTE: the working register and captured op are reset too; they are
      // cheap flops and a known value keeps the datapath free of X after reset.
      work      <= '0;
      held_op   <= OP_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            held_op <= op_e'(op);
            work    <= in1;
            if (is_shift_op(op_e'(op)) && (shift != '0)) begin
              count    <= shift;
              state    <= SHIFT;
              in_ready <= 1'b0;
            end else begin
              out                          <= core_result;
              {negative, zero, positive}   <= cc_result;
              overflow                     <= core_overflow;
              state                        <= DONE;
              in_ready                     <= 1'b0;
              out_valid                    <= 1'b1;
            end
          end
        end

        SHIFT: begin
          work  <= core_step;
          count <= count - SHW'(1);
          // The last single-bit step lands directly in the output registers,
          // so DONE is entered on the edge where the counter reaches zero.
          if (count <= SHW'(1)) begin
            out                        <= core_step;
            {negative, zero, positive} <= cc_step;
            overflow                   <= 1'b0;
            state                      <= DONE;
            out_valid                  <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 16).
// A table of operations with hand-derived results is applied in order; each
// expected record is pushed to a scoreboard when the bundle is driven and
// popped when out_valid is seen. A reset-abort sequence is written by hand.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;
  localparam int MAX_WAIT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       op;
  logic [SHW-1:0]   shift;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             negative;
  logic             zero;
  logic             positive;
  logic             overflow;

  alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .negative  (negative),
    .zero      (zero),
    .positive  (positive),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e              vop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             n;
    logic             z;
    logic             p;
    logic             v;
    int               lat;
    int               hold;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             n;
    logic             z;
    logic             p;
    logic             v;
    int               lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic add_vec(input op_e vop, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [SHW-1:0] sh, input logic [WIDTH-1:0] res,
                         input logic n, input logic z, input logic p, input logic v,
                         input int lat, input int hold);
    vec_t t;
    t.vop = vop; t.a = a; t.b = b; t.sh = sh; t.res = res;
    t.n = n; t.z = z; t.p = p; t.v = v; t.lat = lat; t.hold = hold;
    vecs.push_back(t);
  endtask

  // Drives one bundle, scrambles the inputs while busy (they must be ignored),
  // compares the result on out_valid, optionally holds DONE, then handshakes.
  task automatic run_vec(input vec_t t);
    exp_t e;
    exp_t got;
    int   w;
    int   lat;
    logic [WIDTH-1:0] held;
    w = 0;
    while (!in_ready && w < MAX_WAIT) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = t.vop; in1 = t.a; in2 = t.b; shift = t.sh;
    e.res = t.res; e.n = t.n; e.z = t.z; e.p = t.p; e.v = t.v; e.lat = t.lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      in_valid = 1'b1;
      op = 3'($urandom); in1 = 16'($urandom); in2 = 16'($urandom); shift = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    got = sb.pop_front();
    check("latency", 32'(lat), 32'(got.lat));
    check("out", 32'(out), 32'(got.res));
    check("negative", 32'(negative), 32'(got.n));
    check("zero", 32'(zero), 32'(got.z));
    check("positive", 32'(positive), 32'(got.p));
    check("overflow", 32'(overflow), 32'(got.v));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    held = out;
    for (int i = 0; i < t.hold; i++) begin
      in_valid = 1'b1;
      in1 = 16'($urandom); in2 = 16'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_out", 32'(out), 32'(got.res));
      check("hold_zero", 32'(zero), 32'(got.z));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_kept", 32'(out), 32'(held));
  endtask

  initial begin
    int seen;
    vec_t tail;

    //        op        in1       in2       sh    result    n     z     p     v    lat hold
    add_vec(OP_ADD,   16'd15,   16'd37,   4'd0, 16'h0034, 1'b0, 1'b0, 1'b1, 1'b0,  1, 0);
    add_vec(OP_ADD,   16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1,  1, 0);
    add_vec(OP_ADD,   16'h8000, 16'h8000, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1,  1, 0);
    add_vec(OP_AND,   16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 1'b0, 1'b0, 1'b1, 1'b0,  1, 0);
    add_vec(OP_ADD,   16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0,  1, 0);
    add_vec(OP_ADD,   16'h8000, 16'hFFFF, 4'd0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1,  1, 0);
    add_vec(OP_XOR,   16'hA5A5, 16'hA5A5, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0,  1, 5);
    add_vec(OP_NOT,   16'h00FF, 16'h1234, 4'd0, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0,  1, 0);
    add_vec(OP_LSHF,  16'h0001, 16'h0000, 4'd13, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b0, 14, 0);
    add_vec(OP_RSHFA, 16'h8000, 16'h0000, 4'd4, 16'hF800, 1'b1, 1'b0, 1'b0, 1'b0,  5, 0);
    add_vec(OP_RSHFL, 16'h8000, 16'h0000, 4'd4, 16'h0800, 1'b0, 1'b0, 1'b1, 1'b0,  5, 0);
    add_vec(OP_LSHF,  16'h8001, 16'h0000, 4'd0, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0,  1, 0);
    add_vec(OP_RSHFA, 16'h4000, 16'h0000, 4'd15, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16, 0);
    add_vec(OP_LSHF,  16'hFFFF, 16'h0000, 4'd1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0,  2, 2);
    add_vec(OP_NOT,   16'hFFFF, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0,  1, 0);
    add_vec(OP_PASS,  16'hFFFF, 16'h1234, 4'd7, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0,  1, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; op = '0; shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", 32'({negative, zero, positive, overflow}), 32'b0100);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the 3rd SHIFT cycle of a 10-bit shift aborts the op.
    check("abort_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = OP_LSHF; in1 = 16'h0001; in2 = '0; shift = 4'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_c1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_c2_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    check("abort_out", 32'(out), 32'd0);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    tail = vecs[0];
    run_vec(tail);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
